// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 codes,
// the M-extension funct7 value, FSM state and iteration-step mode.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        ITER_MUL = 1'b0,
        ITER_DIV = 1'b1
    } iter_mode_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// The accumulator is {high half, low half}; the divider keeps {remainder, dividend/quotient}.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  iter_mode_e        mode_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              q_bit_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;

    always_comb begin
        add_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_shift = acc_i[2*XLEN-1:XLEN-1];
        trial     = rem_shift - {1'b0, opnd_i};
        acc_o     = '0;
        q_bit_o   = 1'b0;
        if (mode_i == ITER_MUL) begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end else begin
            // remainder stays below the divisor, so bit XLEN of the trial is a clean borrow
            q_bit_o = ~trial[XLEN];
            acc_o   = {(q_bit_o ? trial[XLEN-1:0] : rem_shift[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies, divides still iterate.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic              neg_a_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;

    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] acc_nxt;
    logic              q_bit;
    iter_mode_e        iter_mode;

    function automatic logic [XLEN-1:0] pick_result(
        input logic [2:0]      f3,
        input logic [2*XLEN-1:0] acc,
        input logic            neg,
        input logic            neg_a
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            F3_MUL:                       pick_result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: pick_result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              pick_result = quo;
            default:                      pick_result = rem;
        endcase
    endfunction

    always_comb begin
        a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        sign_a   = a_signed & op_a_i[XLEN-1];
        sign_b   = b_signed & op_b_i[XLEN-1];
        mag_a    = sign_a ? -op_a_i : op_a_i;
        mag_b    = sign_b ? -op_b_i : op_b_i;

        div_zero = is_div_op(funct3_i) && (op_b_i == '0);
        div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                   (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);

        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? op_a_i : '1;
        end else if (div_ovf) begin
            special_res = funct3_i[1] ? '0 : op_a_i;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    assign iter_mode = is_div_op(f3_q) ? ITER_DIV : ITER_MUL;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .mode_i  (iter_mode),
        .acc_o   (acc_step),
        .q_bit_o (q_bit)
    );

    assign acc_nxt = {acc_step[2*XLEN-1:1], acc_step[0] | q_bit};

    // combinational so the front end freezes in the same cycle the instruction is accepted
    assign stall_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == BUSY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            f3_q    <= funct3_i;
                            neg_q   <= sign_a ^ sign_b;
                            neg_a_q <= sign_a;
                            if (div_zero || div_ovf) begin
                                result_o <= special_res;
                                valid_o  <= 1'b1;
                                state_q  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                            end else if (!is_div_op(funct3_i)) begin
                                result_o <= pick_result(funct3_i, fast_prod, sign_a ^ sign_b, sign_a);
                                valid_o  <= 1'b1;
                                state_q  <= DONE;
`endif
                            end else begin
                                if (is_div_op(funct3_i)) begin
                                    acc_q  <= {{XLEN{1'b0}}, mag_a};
                                    opnd_q <= mag_b;
                                end else begin
                                    acc_q  <= {{XLEN{1'b0}}, mag_b};
                                    opnd_q <= mag_a;
                                end
                                cnt_q   <= CW'(XLEN);
                                busy_o  <= 1'b1;
                                state_q <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            result_o <= pick_result(f3_q, acc_nxt, neg_q, neg_a_q);
                            valid_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latency, stall window, flush and async reset.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int ITER_LAT = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = ITER_LAT;
`endif

    logic            clk_i    = 1'b0;
    logic            rst_ni   = 1'b0;
    logic            start_i  = 1'b0;
    logic            flush_i  = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] op_a_i   = '0;
    logic [XLEN-1:0] op_b_i   = '0;
    logic            stall_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;

    vec_t vecs[15];

    always #5 clk_i = ~clk_i;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // start held until valid_o is seen, as EX would; operands scrambled after accept
    task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output int lat, output int stall_cnt, output logic [XLEN-1:0] res);
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        @(posedge clk_i);
        #1;
        op_a_i = ~a ^ 32'h1234_5678;
        op_b_i = ~b;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (stall_o) stall_cnt++;
            if (valid_o) break;
        end
        res     = result_o;
        start_i = 1'b0;
    endtask

    initial begin
        int lat;
        int stall_cnt;
        int seen_valid;
        logic [XLEN-1:0] res;

        vecs = '{
            '{F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
            '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
            '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT},
            '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT},
            '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT},
            '{F3_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, ITER_LAT},
            '{F3_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, ITER_LAT},
            '{F3_DIVU,   32'd100,      32'd7,        32'd14,        ITER_LAT},
            '{F3_REMU,   32'd100,      32'd7,        32'd2,         ITER_LAT},
            '{F3_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1},
            '{F3_REM,    32'd5,        32'd0,        32'd5,         1},
            '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1},
            '{F3_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         ITER_LAT},
            '{F3_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, ITER_LAT}
        };

        #12;
        expect_eq("reset_stall",  {63'd0, stall_o}, 64'd0);
        expect_eq("reset_busy",   {63'd0, busy_o},  64'd0);
        expect_eq("reset_valid",  {63'd0, valid_o}, 64'd0);
        expect_eq("reset_result", {32'd0, result_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, stall_cnt, res);
            expect_eq($sformatf("v%0d_result", i), {32'd0, res}, {32'd0, vecs[i].res});
            expect_eq($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            expect_eq($sformatf("v%0d_stall_cycles", i), 64'(stall_cnt), 64'(vecs[i].lat));
        end

        // flush at BUSY iteration 10; last result was 0xFFFFFFFD
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = F3_DIVU;
        op_a_i   = 32'd1000;
        op_b_i   = 32'd3;
        @(posedge clk_i);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        expect_eq("flush_busy_before", {63'd0, busy_o}, 64'd1);
        flush_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        expect_eq("flush_busy",   {63'd0, busy_o},   64'd0);
        expect_eq("flush_valid",  {63'd0, valid_o},  64'd0);
        expect_eq("flush_stall",  {63'd0, stall_o},  64'd0);
        expect_eq("flush_result", {32'd0, result_o}, 64'hFFFF_FFFD);
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (valid_o) seen_valid++;
        end
        expect_eq("flush_no_valid", 64'(seen_valid), 64'd0);

        run_op(F3_MUL, 32'd3, 32'd5, lat, stall_cnt, res);
        expect_eq("post_flush_mul_result",  {32'd0, res}, 64'd15);
        expect_eq("post_flush_mul_latency", 64'(lat), 64'(MUL_LAT));

        // async reset in the middle of a divide
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = F3_DIVU;
        op_a_i   = 32'd1000;
        op_b_i   = 32'd3;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #2;
        start_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        expect_eq("areset_busy",   {63'd0, busy_o},   64'd0);
        expect_eq("areset_valid",  {63'd0, valid_o},  64'd0);
        expect_eq("areset_stall",  {63'd0, stall_o},  64'd0);
        expect_eq("areset_result", {32'd0, result_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(F3_REMU, 32'd1000, 32'd3, lat, stall_cnt, res);
        expect_eq("post_reset_remu_result", {32'd0, res}, 64'd1);
        expect_eq("post_reset_remu_latency", 64'(lat), 64'(ITER_LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
